// File: rtl/crossbar_rr_if.sv
// Master-side and slave-side request/response buses of the crossbar_rr switch.
// The crossbar connects through the slave modport; the surrounding masters and slaves use the master modport.
interface crossbar_rr_if #(
    parameter int M  = 4,
    parameter int S  = 4,
    parameter int DW = 32,
    parameter int AW = 32
);
    localparam int SAW = AW - $clog2(S);

    logic [M-1:0]                m_req;
    logic [M-1:0]                m_cmd;
    logic [M-1:0][AW-1:0]        m_addr;
    logic [M-1:0][DW-1:0]        m_wdata;
    logic [M-1:0]                m_ack;
    logic [M-1:0]                m_resp;
    logic [M-1:0][DW-1:0]        m_rdata;

    logic [S-1:0]                s_req;
    logic [S-1:0]                s_cmd;
    logic [S-1:0][SAW-1:0]       s_addr;
    logic [S-1:0][DW-1:0]        s_wdata;
    logic [S-1:0]                s_ack;
    logic [S-1:0]                s_resp;
    logic [S-1:0][DW-1:0]        s_rdata;

    modport slave (
        input  m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
        output m_ack, m_resp, m_rdata, s_req, s_cmd, s_addr, s_wdata
    );

    modport master (
        output m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
        input  m_ack, m_resp, m_rdata, s_req, s_cmd, s_addr, s_wdata
    );
endinterface

// File: rtl/crossbar_rr.sv
// M x S request/response crossbar with one round-robin arbiter FSM per slave port.
// Optional macro CROSSBAR_TIMEOUT_EN adds a per-slave response timeout returning all-ones data.
module crossbar_rr #(
    parameter int M       = 4,
    parameter int S       = 4,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    crossbar_rr_if.slave   bus
);
    localparam int SW  = $clog2(S);
    localparam int SAW = AW - SW;
    localparam int GW  = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r [S];
    state_t              state_s [S];
    logic [GW-1:0]       grant_r [S];
    logic [GW-1:0]       grant_s [S];
    logic [GW-1:0]       last_r  [S];
    logic [GW-1:0]       last_s  [S];
    logic [S-1:0]        done_s;
    logic [S-1:0][DW-1:0] done_data_s;

`ifdef CROSSBAR_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]          cnt_r [S];
    logic [7:0]          cnt_s [S];
`endif

    // Completion of the current slave transaction: real response, or timeout with all-ones data.
    always_comb begin
        for (int s = 0; s < S; s++) begin
`ifdef CROSSBAR_TIMEOUT_EN
            done_s[s]      = bus.s_resp[s] | ((state_r[s] == ST_WAIT) && (cnt_r[s] == TMO_LAST));
            done_data_s[s] = bus.s_resp[s] ? bus.s_rdata[s] : {DW{1'b1}};
`else
            done_s[s]      = bus.s_resp[s];
            done_data_s[s] = bus.s_rdata[s];
`endif
        end
    end

    // Arbiter state, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < S; s++) begin
                state_r[s] <= ST_IDLE;
                grant_r[s] <= '0;
                last_r[s]  <= GW'(M - 1);
`ifdef CROSSBAR_TIMEOUT_EN
                cnt_r[s]   <= 8'd0;
`endif
            end
        end else begin
            for (int s = 0; s < S; s++) begin
                state_r[s] <= state_s[s];
                grant_r[s] <= grant_s[s];
                last_r[s]  <= last_s[s];
`ifdef CROSSBAR_TIMEOUT_EN
                cnt_r[s]   <= cnt_s[s];
`endif
            end
        end
    end

    // Next-state logic; descending scan so the candidate closest after last_grant wins.
    always_comb begin
        logic [GW-1:0] cand;
        logic          hit;
        cand = '0;
        hit  = 1'b0;
        for (int s = 0; s < S; s++) begin
            state_s[s] = state_r[s];
            grant_s[s] = grant_r[s];
            last_s[s]  = last_r[s];
`ifdef CROSSBAR_TIMEOUT_EN
            cnt_s[s]   = 8'd0;
`endif
            case (state_r[s])
                ST_IDLE: begin
                    for (int k = M - 1; k >= 0; k--) begin
                        cand       = GW'((int'(last_r[s]) + 1 + k) % M);
                        hit        = bus.m_req[cand] && (bus.m_addr[cand][AW-1 -: SW] == SW'(s));
                        grant_s[s] = hit ? cand : grant_s[s];
                        last_s[s]  = hit ? cand : last_s[s];
                        state_s[s] = hit ? ST_REQ : state_s[s];
                    end
                end
                ST_REQ: begin
                    state_s[s] = bus.s_ack[s] ? ST_WAIT : ST_REQ;
                end
                ST_WAIT: begin
                    state_s[s] = done_s[s] ? ST_IDLE : ST_WAIT;
`ifdef CROSSBAR_TIMEOUT_EN
                    cnt_s[s]   = done_s[s] ? 8'd0 : (cnt_r[s] + 8'd1);
`endif
                end
                default: begin
                    state_s[s] = ST_IDLE;
                end
            endcase
        end
    end

    // Combinational routing between the granted master and its slave.
    always_comb begin
        bus.m_ack   = '0;
        bus.m_resp  = '0;
        bus.m_rdata = '0;
        bus.s_req   = '0;
        bus.s_cmd   = '0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        for (int s = 0; s < S; s++) begin
            case (state_r[s])
                ST_REQ: begin
                    bus.s_req[s]            = 1'b1;
                    bus.s_cmd[s]            = bus.m_cmd[grant_r[s]];
                    bus.s_addr[s]           = bus.m_addr[grant_r[s]][SAW-1:0];
                    bus.s_wdata[s]          = bus.m_wdata[grant_r[s]];
                    bus.m_ack[grant_r[s]]   = bus.s_ack[s];
                end
                ST_WAIT: begin
                    bus.m_resp[grant_r[s]]  = done_s[s];
                    bus.m_rdata[grant_r[s]] = done_s[s] ? done_data_s[s] : {DW{1'b0}};
                end
                default: begin
                    bus.s_req[s]            = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crossbar_rr.sv
// Directed plus randomized bench for crossbar_rr against a transaction-level reference model.
module tb_crossbar_rr;
    localparam int M   = 4;
    localparam int S   = 4;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TO  = 16;
    localparam int SW  = 2;
    localparam int SAW = AW - SW;
`ifdef CROSSBAR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    crossbar_rr_if #(.M(M), .S(S), .DW(DW), .AW(AW)) bus ();
    crossbar_rr #(.M(M), .S(S), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // reference model: who owns each slave, whether the ack happened, cycles in phase
    int owner [S];
    int last  [S];
    int age   [S];
    bit acked [S];
    // master and slave stimulus state
    bit pend  [M];
    bit waitr [M];
    bit mcmd  [M];
    logic [AW-1:0] maddr [M];
    logic [DW-1:0] mdat  [M];
    logic [DW-1:0] srd   [S];
    int ack_lat  [S];
    int resp_lat [S];
    bit stray    [S];
    bit rmode;
    // expected outputs
    logic [M-1:0]   e_ack, e_resp, e_sreq, e_scmd;
    logic [DW-1:0]  e_rdata [M];
    logic [SAW-1:0] e_saddr [S];
    logic [DW-1:0]  e_swd   [S];
    int grant_log [$];
    int vectors;
    int miscompares;

    function automatic int tgt(input logic [AW-1:0] a);
        return int'(a >> (AW - SW));
    endfunction

    function automatic bit busy();
        bit b = 1'b0;
        for (int i = 0; i < M; i++) b = b | pend[i] | waitr[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compute_expect();
        e_ack = '0; e_resp = '0; e_sreq = '0; e_scmd = '0;
        for (int i = 0; i < M; i++) e_rdata[i] = '0;
        for (int s = 0; s < S; s++) begin
            e_saddr[s] = '0;
            e_swd[s]   = '0;
        end
        if (!rst) begin
            for (int s = 0; s < S; s++) begin
                int o = owner[s];
                if (o >= 0) begin
                    if (!acked[s]) begin
                        e_sreq[s]  = 1'b1;
                        e_scmd[s]  = mcmd[o];
                        e_saddr[s] = SAW'(maddr[o] % (64'd1 << SAW));
                        e_swd[s]   = mdat[o];
                        e_ack[o]   = bus.s_ack[s];
                    end else if (bus.s_resp[s]) begin
                        e_resp[o]  = 1'b1;
                        e_rdata[o] = srd[s];
                    end else if (TO_EN && age[s] == TO) begin
                        e_resp[o]  = 1'b1;
                        e_rdata[o] = {DW{1'b1}};
                    end
                end
            end
        end
    endtask

    task automatic drive();
        if (rst) begin
            for (int s = 0; s < S; s++) begin
                owner[s] = -1; last[s] = M - 1; acked[s] = 1'b0; age[s] = 0;
            end
            for (int i = 0; i < M; i++) begin
                pend[i] = 1'b0; waitr[i] = 1'b0;
            end
        end
        if (rmode && !rst) begin
            for (int i = 0; i < M; i++) begin
                if (!pend[i] && !waitr[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    mcmd[i]  = 1'($urandom_range(0, 1));
                    maddr[i] = $urandom;
                    mdat[i]  = $urandom;
                end
            end
        end
        for (int i = 0; i < M; i++) begin
            bus.m_req[i]   = pend[i];
            bus.m_cmd[i]   = mcmd[i];
            bus.m_addr[i]  = maddr[i];
            bus.m_wdata[i] = mdat[i];
        end
        for (int s = 0; s < S; s++) begin
            srd[s]         = $urandom;
            bus.s_rdata[s] = srd[s];
            if (rmode) begin
                bus.s_ack[s]  = ($urandom_range(0, 2) == 0);
                bus.s_resp[s] = ($urandom_range(0, 2) == 0);
            end else begin
                bus.s_ack[s]  = (owner[s] >= 0) && !acked[s] && (age[s] >= ack_lat[s]);
                bus.s_resp[s] = ((owner[s] >= 0) && acked[s] && (age[s] >= resp_lat[s])) || stray[s];
                stray[s]      = 1'b0;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compute_expect();
        chk("m_ack",  bus.m_ack,  e_ack);
        chk("m_resp", bus.m_resp, e_resp);
        chk("s_req",  bus.s_req,  e_sreq);
        chk("s_cmd",  bus.s_cmd,  e_scmd);
        for (int i = 0; i < M; i++) begin
            if (bus.m_ack[i]) grant_log.push_back(i);
            chk($sformatf("m_rdata%0d", i), bus.m_rdata[i], e_rdata[i]);
        end
        for (int s = 0; s < S; s++) begin
            chk($sformatf("s_addr%0d", s),  bus.s_addr[s],  e_saddr[s]);
            chk($sformatf("s_wdata%0d", s), bus.s_wdata[s], e_swd[s]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            for (int s = 0; s < S; s++) begin
                if (owner[s] < 0) begin
                    bit got = 1'b0;
                    for (int k = 1; k <= M; k++) begin
                        int c = (last[s] + k) % M;
                        if (!got && pend[c] && tgt(maddr[c]) == s) begin
                            got = 1'b1; owner[s] = c; last[s] = c; acked[s] = 1'b0; age[s] = 0;
                        end
                    end
                end else if (!acked[s]) begin
                    if (bus.s_ack[s]) begin
                        acked[s] = 1'b1; age[s] = 1;
                    end else begin
                        age[s]++;
                    end
                end else if (bus.s_resp[s] || (TO_EN && age[s] == TO)) begin
                    owner[s] = -1; acked[s] = 1'b0;
                end else begin
                    age[s]++;
                end
            end
            for (int i = 0; i < M; i++) begin
                if (e_ack[i]) begin pend[i] = 1'b0; waitr[i] = 1'b1; end
                if (e_resp[i]) waitr[i] = 1'b0;
            end
        end
        #1;
        drive();
    endtask

    task automatic issue(input int i, input bit c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i] = 1'b1; mcmd[i] = c; maddr[i] = a; mdat[i] = d;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        while (busy() && n < budget) begin
            settle();
            advance();
            n++;
        end
        chk(tag, 64'(busy()), 64'd0);
    endtask

    initial begin
        bit seen0, seen1;
        vectors = 0; miscompares = 0; rmode = 1'b0; rst = 1'b1;
        for (int s = 0; s < S; s++) begin
            ack_lat[s] = 0; resp_lat[s] = 1; stray[s] = 1'b0;
        end
        for (int i = 0; i < M; i++) begin
            mcmd[i] = 1'b0; maddr[i] = '0; mdat[i] = '0;
        end
        #1 drive();
        // activity on every input while reset is held must not reach any output
        bus.m_req = '1; bus.s_ack = '1; bus.s_resp = '1;
        settle();
        chk("reset_outputs", {bus.m_ack, bus.m_resp, bus.s_req}, 12'h000);
        advance();
        rst = 1'b0;
        drive();

        // four masters contend for slave 1: round robin from master 0
        for (int s = 0; s < S; s++) begin ack_lat[s] = 1; resp_lat[s] = 2; end
        grant_log.delete();
        for (int i = 0; i < M; i++) issue(i, 1'b0, 32'h4000_0000, $urandom);
        drive();
        settle();
        advance();
        settle();
        chk("rr_first_sreq", bus.s_req, 4'b0010);
        chk("rr_first_saddr", bus.s_addr[1], 30'h0);
        advance();
        run_until_idle(80, "rr_drain");
        chk("rr_grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_grant%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, k);

        // master 2 writes slave 3 with a zero-latency ack
        for (int s = 0; s < S; s++) begin ack_lat[s] = 0; resp_lat[s] = 1; end
        issue(2, 1'b1, 32'hC000_0010, 32'hA5A5_A5A5);
        drive();
        settle();
        chk("wr_c0_sreq", bus.s_req, 4'b0000);
        advance();
        settle();
        chk("wr_sreq", bus.s_req, 4'b1000);
        chk("wr_saddr", bus.s_addr[3], 30'h10);
        chk("wr_wdata", bus.s_wdata[3], 32'hA5A5_A5A5);
        chk("wr_cmd", bus.s_cmd[3], 1'b1);
        chk("wr_ack", bus.m_ack, 4'b0100);
        advance();
        run_until_idle(20, "wr_drain");

        // independent slaves serve two masters concurrently
        resp_lat[0] = 3; resp_lat[2] = 2;
        issue(0, 1'b0, 32'h0000_0040, 32'h0);
        issue(1, 1'b0, 32'h8000_0080, 32'h0);
        drive();
        settle();
        advance();
        settle();
        chk("conc_sreq", bus.s_req, 4'b0101);
        seen0 = 1'b0; seen1 = 1'b0;
        for (int n = 0; n < 10; n++) begin
            advance();
            settle();
            if (e_resp[0]) begin seen0 = 1'b1; chk("conc_rdata0", bus.m_rdata[0], srd[0]); end
            if (e_resp[1]) begin seen1 = 1'b1; chk("conc_rdata1", bus.m_rdata[1], srd[2]); end
        end
        chk("conc_both_done", {seen0, seen1}, 2'b11);
        advance();
        run_until_idle(10, "conc_drain");

        // reset during WAIT_RESP, stray response afterwards, then a clean new grant
        resp_lat[1] = 100;
        issue(3, 1'b0, 32'h4000_0004, 32'h0);
        drive();
        repeat (4) begin settle(); advance(); end
        rst = 1'b1;
        drive();
        settle();
        chk("midrst_outputs", {bus.m_ack, bus.m_resp, bus.s_req}, 12'h000);
        advance();
        rst = 1'b0;
        stray[1] = 1'b1;
        drive();
        settle();
        chk("midrst_stray_resp", bus.m_resp, 4'b0000);
        advance();
        resp_lat[1] = 1;
        issue(0, 1'b0, 32'h4000_0008, 32'h0);
        drive();
        settle();
        advance();
        settle();
        chk("midrst_regrant_sreq", bus.s_req, 4'b0010);
        chk("midrst_regrant_ack", bus.m_ack, 4'b0001);
        advance();
        run_until_idle(20, "midrst_drain");

        // slave 0 never responds: timeout (if built in) exactly TO cycles after the ack
        resp_lat[0] = 1000;
        issue(2, 1'b0, 32'h0000_0000, 32'h0);
        drive();
        settle();
        advance();
        settle();
        chk("tmo_ack", bus.m_ack, 4'b0100);
        for (int n = 1; n <= 20; n++) begin
            advance();
            if (n == 16) begin
                issue(1, 1'b0, 32'h0000_0004, 32'h0);
                drive();
            end
            settle();
            chk($sformatf("tmo_resp_c%0d", n), bus.m_resp, (TO_EN && n == 16) ? 4'b0100 : 4'b0000);
            if (n == 16) chk("tmo_rdata", bus.m_rdata[2], TO_EN ? 32'hFFFF_FFFF : 32'h0);
            if (n == 18) chk("tmo_regrant", bus.s_req[0], TO_EN);
        end
        advance();
        rst = 1'b1;
        drive();
        settle();
        advance();
        rst = 1'b0;
        drive();

        // randomized traffic, including acks/responses outside their valid states
        rmode = 1'b1;
        repeat (600) begin
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/crossbar_rr.md
CROSSBAR_RR -- requirements
Module: crossbar_rr

Interface
REQ-001 Parameter M, default 4: number of master ports, 1..16.
REQ-002 Parameter S, default 4: number of slave ports, power of two, 2..16.
REQ-003 Parameter DW, default 32: data width of wdata/rdata.
REQ-004 Parameter AW, default 32: master address width; slave address width is SAW = AW-$clog2(S).
REQ-005 Parameter TIMEOUT, default 16: response timeout in cycles, 2..255; used only when CROSSBAR_TIMEOUT_EN is defined.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-007 m_req input 1[M]: master request, held until m_ack.
REQ-008 m_cmd input 1[M]: 1 = write, 0 = read.
REQ-009 m_addr input AW[M]: top $clog2(S) bits select the slave; the remainder is the slave address.
REQ-010 m_wdata input DW[M]: write data.
REQ-011 m_ack output 1[M]: one-cycle request accept.
REQ-012 m_resp output 1[M]: one-cycle completion pulse.
REQ-013 m_rdata output DW[M]: read data, valid with m_resp.
REQ-014 s_req output 1[S], s_cmd output 1[S], s_addr output SAW[S], s_wdata output DW[S]: forwarded request.
REQ-015 s_ack input 1[S], s_resp input 1[S], s_rdata input DW[S]: slave accept, completion and read data.

Function
REQ-016 Each slave port SHALL have an independent arbiter FSM with states IDLE, REQ, WAIT_RESP and a registered grant index.
REQ-017 IDLE: on any master with m_req=1 decoding to this slave, register the grant using round-robin and enter REQ; the first candidate is at (last_grant+1) mod M.
REQ-018 REQ: s_req=1 and s_cmd/s_addr/s_wdata are muxed combinationally from the granted master; s_ack is routed combinationally to m_ack of that master; on s_ack enter WAIT_RESP.
REQ-019 WAIT_RESP: s_req=0; s_resp/s_rdata are routed combinationally to m_resp/m_rdata of the granted master; on s_resp enter IDLE.
REQ-020 Latency: m_req at cycle 0 with the slave idle gives s_req at cycle 1; a zero-latency s_ack gives m_ack at cycle 1; a new grant is possible in the cycle after s_resp.
REQ-021 One transaction per slave is in flight at a time; a master targeting a busy slave waits with m_req held and receives no ack.
REQ-022 A master SHALL be granted by at most one slave at a time, because it addresses exactly one slave.
REQ-023 Simultaneous requests from masters i<j when last_grant=i: j wins; when last_grant>=j: i wins.
REQ-024 s_ack in IDLE or WAIT_RESP, and s_resp in IDLE or REQ, SHALL be ignored.
REQ-025 Ungranted master outputs m_ack, m_resp and m_rdata SHALL be 0.
REQ-026 Address split: slave = m_addr[AW-1 -: $clog2(S)]; s_addr = m_addr[SAW-1:0].

Reset
REQ-027 rst=1 asynchronously forces all arbiters to IDLE, last_grant to M-1, and grant invalid; any transaction in flight is abandoned.
REQ-028 During reset all outputs SHALL be 0.
REQ-029 Slave responses arriving after a mid-transaction reset are discarded per REQ-024.

Configuration
REQ-030 Macro CROSSBAR_TIMEOUT_EN defined: a per-slave counter runs in WAIT_RESP; after TIMEOUT cycles without s_resp the block SHALL pulse m_resp with m_rdata = all ones, and the arbiter SHALL enter IDLE.
REQ-031 Macro CROSSBAR_TIMEOUT_EN undefined: no counter is present and WAIT_RESP waits indefinitely.

Verification
REQ-032 Masters 0..3 all request slave 1 (m_addr=32'h4000_0000) with 1-cycle ack and 2-cycle resp -> grants in order 0,1,2,3; s_addr=30'h0.
REQ-033 Master 2 writes slave 3 addr 32'hC000_0010 data 32'hA5A5_A5A5 -> s_req[3] at cycle 1, s_addr=30'h10, s_wdata matches; master 2 is acked; no other slave sees a request.
REQ-034 Master 0 reads slave 0 while master 1 reads slave 2 -> both proceed concurrently; m_rdata[0]=s_rdata[0] and m_rdata[1]=s_rdata[2] on their respective resp cycles.
REQ-035 rst asserted during WAIT_RESP, then a stray s_resp after release -> no m_resp; the next request is granted normally.
REQ-036 With CROSSBAR_TIMEOUT_EN and TIMEOUT=16, slave never responds -> m_resp with rdata=32'hFFFF_FFFF exactly 16 cycles after ack, and the slave is re-grantable next cycle; without the macro -> no m_resp.
